ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Pipeline register directly downstream of the 32-bit ALU; captures ALU Result/Zero/Overflow/Carryout plus EX control bits and presents them to the MEM stage.
- Resolves beq/bne from the ALU Zero flag.
- Applies signed-overflow trapping with a TRAP state held until acknowledged.
- Supports stall and flush from the hazard unit.

Parameters:
- CNT_W, 8, width of the saturating overflow-event counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all registered outputs
- flush  in  1  capture a bubble instead of EX contents
- ex_valid  in  1  EX slot holds a real instruction
- ex_pc  in  32  PC of EX instruction
- alu_result  in  32  ALU Result
- alu_zero  in  1  ALU Zero
- alu_overflow  in  1  ALU Overflow
- alu_carryout  in  1  ALU Carryout
- rt_data  in  32  store data
- dest_reg  in  5  destination register number
- reg_write, mem_read, mem_write, mem_to_reg  in  1 each  EX control bits
- branch_eq, branch_ne  in  1 each  branch type
- ovf_trap_en  in  1  instruction traps on overflow (add/sub, not addu/subu)
- branch_target  in  32  computed branch target
- exc_ack  in  1  exception handler acknowledge (single-cycle pulse)
- mem_valid  out  1  registered valid
- mem_alu_result  out  32  registered ALU result
- mem_carry  out  1  registered Carryout
- mem_store_data  out  32  registered rt_data
- mem_dest_reg  out  5  registered destination
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each  registered control
- pc_redirect  out  1  one-cycle pulse, branch taken
- redirect_target  out  32  target valid while pc_redirect=1
- exc_overflow  out  1  high while in TRAP
- epc  out  32  PC of trapping instruction
- ovf_count  out  CNT_W  saturating count of traps taken

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0 and state goes to RUN.
  - Reset mid-TRAP or mid-stall discards everything.
- Latency: 1 cycle from EX inputs to mem_* outputs. All outputs are registered.
- Capture priority, evaluated at the rising clk edge:
  1. flush: bubble.
  2. stall: hold.
  3. state==TRAP: bubble.
  4. Otherwise: normal capture.
- Bubble:
  - mem_valid, all four control outputs, and mem_carry are 0.
  - Data fields (result, store data, dest) are 0.
- Hold (stall):
  - Every mem_* output, epc and ovf_count keep their values.
  - pc_redirect forced 0.
  - exc_ack is still honoured.
- Normal capture when ex_valid=0: same as bubble.
- Normal capture when ex_valid=1:
  - All fields copied; mem_valid=1.
  - trap = ovf_trap_en & alu_overflow.
  - If trap:
    - mem_reg_write, mem_mem_read, mem_mem_write and mem_mem_to_reg are forced 0; result and dest are still captured.
    - epc <= ex_pc.
    - ovf_count increments, saturating at all-ones.
    - state -> TRAP.
  - taken = (branch_eq & alu_zero) | (branch_ne & ~alu_zero), ignored when trap.
  - If taken: pc_redirect=1 for exactly one cycle; redirect_target <= branch_target.
  - If not taken: pc_redirect=0; redirect_target holds its previous value.
- State machine:
  - RUN -> TRAP on a trap capture.
  - TRAP -> RUN on exc_ack, regardless of stall. The RUN state is visible from the following edge.
  - exc_ack in RUN is ignored.
  - exc_overflow = (state==TRAP), registered.
- Simultaneous events:
  - flush and stall together: flush wins, and no redirect is produced.
  - exc_ack and a trap-causing capture in the same cycle: impossible, since captures are bubbled while in TRAP. The ack returns the block to RUN, and the next edge captures normally.
  - branch_eq and branch_ne both high: taken = 1. This is illegal from decode; the bench does not rely on it.
- Arithmetic and widths:
  - No arithmetic except ovf_count + 1 (CNT_W bits, saturating).
  - All 32-bit paths are pass-through.

Test Plan:
1. Reset then plain capture: rst pulse, then ex_valid=1, alu_result=0x0000_0005, dest_reg=9, reg_write=1 -> next edge mem_valid=1, mem_alu_result=5, mem_dest_reg=9, mem_reg_write=1; pc_redirect=0.
2. Branch: branch_eq=1, alu_zero=1, branch_target=0x0040_0020 -> pc_redirect=1 for one cycle, redirect_target=0x0040_0020. Repeat with alu_zero=0 -> pc_redirect=0. bne with alu_zero=0 -> taken.
3. Overflow trap:
   - Stimulus: ex_pc=0x0040_0100, ovf_trap_en=1, alu_overflow=1, reg_write=1.
   - Response: mem_valid=1, mem_reg_write=0, exc_overflow=1, epc=0x0040_0100, ovf_count=1.
   - Next 3 valid instructions -> bubbles (mem_valid=0).
   - exc_ack pulse -> exc_overflow=0 next edge, then normal captures resume.
   - Same overflow with ovf_trap_en=0 -> no trap, mem_reg_write=1.
4. Stall/flush:
   - Capture 0xAAAA_AAAA, then stall=1 for 3 cycles with changing inputs -> outputs stay 0xAAAA_AAAA.
   - flush=1 together with stall=1 -> bubble.
   - Taken branch under stall -> no pc_redirect.
5. Saturation: force 2^CNT_W+2 trap/ack cycles (CNT_W=2 build) -> ovf_count sticks at 3.
6. Async reset mid-TRAP: assert rst between clock edges while exc_overflow=1 -> all outputs 0 immediately, state RUN, ovf_count=0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU flags and EX control, resolves beq/bne, traps on signed overflow.
// Latency 1 cycle; stall holds all mem_* state, flush or TRAP inserts bubbles; no backpressure beyond stall.
module ex_mem_stage #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      alu_result,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             alu_carryout,
   input  logic [31:0]      rt_data,
   input  logic [4:0]       dest_reg,
   input  logic             reg_write,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             mem_to_reg,
   input  logic             branch_eq,
   input  logic             branch_ne,
   input  logic             ovf_trap_en,
   input  logic [31:0]      branch_target,
   input  logic             exc_ack,
   output logic             mem_valid,
   output logic [31:0]      mem_alu_result,
   output logic             mem_carry,
   output logic [31:0]      mem_store_data,
   output logic [4:0]       mem_dest_reg,
   output logic             mem_reg_write,
   output logic             mem_mem_read,
   output logic             mem_mem_write,
   output logic             mem_mem_to_reg,
   output logic             pc_redirect,
   output logic [31:0]      redirect_target,
   output logic             exc_overflow,
   output logic [31:0]      epc,
   output logic [CNT_W-1:0] ovf_count
);

   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

   state_t state, state_nxt;
   logic   capture;
   logic   ovf_hit;
   logic   trap;
   logic   taken;

   always_comb begin
      capture = ~flush & ~stall & (state == RUN) & ex_valid;
      ovf_hit = ovf_trap_en & alu_overflow;
      trap    = capture & ovf_hit;
      taken   = capture & ~ovf_hit & ((branch_eq & alu_zero) | (branch_ne & ~alu_zero));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // The ack releases TRAP even under stall; trap entry only happens from RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (trap)    state_nxt = TRAP;
         TRAP:    if (exc_ack) state_nxt = RUN;
         default:              state_nxt = RUN;
      endcase
   end

   always_comb begin
      exc_overflow = (state == TRAP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid       <= 1'b0;
         mem_alu_result  <= '0;
         mem_carry       <= 1'b0;
         mem_store_data  <= '0;
         mem_dest_reg    <= '0;
         mem_reg_write   <= 1'b0;
         mem_mem_read    <= 1'b0;
         mem_mem_write   <= 1'b0;
         mem_mem_to_reg  <= 1'b0;
         pc_redirect     <= 1'b0;
         redirect_target <= '0;
         epc             <= '0;
         ovf_count       <= '0;
      end else begin
         pc_redirect <= taken;
         if (taken) redirect_target <= branch_target;
         if (trap) begin
            epc <= ex_pc;
            if (ovf_count != {CNT_W{1'b1}}) ovf_count <= ovf_count + CNT_W'(1);
         end
         if (flush || !stall) begin
            if (capture) begin
               mem_valid      <= 1'b1;
               mem_alu_result <= alu_result;
               mem_carry      <= alu_carryout;
               mem_store_data <= rt_data;
               mem_dest_reg   <= dest_reg;
               mem_reg_write  <= reg_write  & ~ovf_hit;
               mem_mem_read   <= mem_read   & ~ovf_hit;
               mem_mem_write  <= mem_write  & ~ovf_hit;
               mem_mem_to_reg <= mem_to_reg & ~ovf_hit;
            end else begin
               mem_valid      <= 1'b0;
               mem_alu_result <= '0;
               mem_carry      <= 1'b0;
               mem_store_data <= '0;
               mem_dest_reg   <= '0;
               mem_reg_write  <= 1'b0;
               mem_mem_read   <= 1'b0;
               mem_mem_write  <= 1'b0;
               mem_mem_to_reg <= 1'b0;
            end
         end
      end
   end

endmodule
